// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
// The slave modport is the controller side; the master modport is the producer/consumer/RAM side.
interface ram_fifo_ctrl_if #(
    parameter int Width = 8,
    parameter int Depth = 16
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int LW = $clog2(Depth + 4);

    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;
    logic [LW-1:0]    level;
    logic             ram_wrEn;
    logic [AW-1:0]    ram_wrAddr;
    logic [Width-1:0] ram_wrData;
    logic [AW-1:0]    ram_rdAddr;
    logic [Width-1:0] ram_rdData;

    modport slave (
        input  in_valid, in_data, out_ready, ram_rdData,
        output in_ready, out_valid, out_data, level,
               ram_wrEn, ram_wrAddr, ram_wrData, ram_rdAddr
    );

    modport master (
        output in_valid, in_data, out_ready, ram_rdData,
        input  in_ready, out_valid, out_data, level,
               ram_wrEn, ram_wrAddr, ram_wrData, ram_rdAddr
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-latency dual-port RAM.
// A 2-entry output buffer absorbs the read latency so both sides sustain one transfer per cycle.
module ram_fifo_ctrl #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_fifo_ctrl_if.slave  bus
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);
    localparam int LW = $clog2(Depth + 4);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    ram_count, ram_count_n;
    logic             pend;
    logic [1:0]       ob_count, ob_left, ob_count_n;
    logic [Width-1:0] ob0, ob1, ob0_n, ob1_n;
    logic [2:0]       ob_after;
    logic             in_fire, pop, rd_fire;

    assign bus.in_ready   = rst_n && (ram_count < CW'(Depth));
    assign bus.out_valid  = (ob_count != 2'd0);
    assign bus.out_data   = ob0;
    assign bus.level      = LW'(ram_count) + LW'(pend) + LW'(ob_count);
    assign bus.ram_wrEn   = in_fire;
    assign bus.ram_wrAddr = wr_ptr;
    assign bus.ram_wrData = bus.in_data;
    assign bus.ram_rdAddr = rd_ptr;

    assign in_fire = bus.in_valid & bus.in_ready;
    assign pop     = bus.out_valid & bus.out_ready;

    always_comb begin
        // Slots committed after this cycle: buffered + in flight - popped.
        ob_after = {1'b0, ob_count} + {2'b00, pend} - {2'b00, pop};
        rd_fire  = (ram_count != '0) && (ob_after < 3'd2);

        unique case ({in_fire, rd_fire})
            2'b10:   ram_count_n = ram_count + CW'(1);
            2'b01:   ram_count_n = ram_count - CW'(1);
            default: ram_count_n = ram_count;
        endcase

        ob_left    = ob_count - {1'b0, pop};
        ob_count_n = ob_left + {1'b0, pend};
        ob0_n      = ob0;
        ob1_n      = ob1;
        if (pop)
            ob0_n = ob1;
        if (pend) begin
            if (ob_left == 2'd0)
                ob0_n = bus.ram_rdData;
            else
                ob1_n = bus.ram_rdData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            pend      <= 1'b0;
            ob_count  <= '0;
            ob0       <= '0;
            ob1       <= '0;
        end else begin
            if (in_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire)
                rd_ptr <= rd_ptr + AW'(1);
            ram_count <= ram_count_n;
            pend      <= rd_fire;
            ob_count  <= ob_count_n;
            ob0       <= ob0_n;
            ob1       <= ob1_n;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, scoreboard monitor, vector tables and directed sequences.
module tb_ram_fifo_ctrl;
    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.Width(W), .Depth(D)) bus ();

    ram_fifo_ctrl #(.Width(W), .Depth(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (bus.ram_wrEn)
            mem[bus.ram_wrAddr] <= bus.ram_wrData;
        bus.ram_rdData <= mem[bus.ram_rdAddr];
    end

    int total = 0;
    int bad = 0;
    int mlevel = 0;
    int npush = 0;
    int npop = 0;
    logic [W-1:0] sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted writes are queued; every pop must match the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mlevel = 0;
        end else begin
            chk("level_model", 32'(bus.level), 32'(mlevel));
            if (bus.out_valid && bus.out_ready) begin
                npop++;
                mlevel--;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_pop_empty actual=%0h required=none at %0t", bus.out_data, $time);
                end else begin
                    logic [W-1:0] e;
                    e = sb.pop_front();
                    chk("sb_data", 32'(bus.out_data), 32'(e));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(bus.in_data);
                npush++;
                mlevel++;
            end
        end
    end

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ev;
        logic [W-1:0] ed;
        logic [4:0]   el;
        logic         eir;
    } vec_t;

    vec_t t1 [5];
    vec_t t5 [12];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string nm);
        bus.in_valid  = v.iv;
        bus.in_data   = v.id;
        bus.out_ready = v.ordy;
        @(negedge clk);
        chk({nm, "_ov"}, 32'(bus.out_valid), 32'(v.ev));
        if (v.ev)
            chk({nm, "_od"}, 32'(bus.out_data), 32'(v.ed));
        chk({nm, "_lvl"}, 32'(bus.level), 32'(v.el));
        chk({nm, "_ir"}, 32'(bus.in_ready), 32'(v.eir));
        cyc();
    endtask

    task automatic drain(input string nm);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.level == '0)
                break;
            cyc();
        end
        chk(nm, 32'(bus.level), 32'd0);
        cyc();
    endtask

    initial begin
        int nxt;
        int p0;
        int q0;
        int sent;
        logic f;
        logic seen;

        for (int i = 0; i < D; i++)
            mem[i] = '0;

        t1[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        t1[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1};
        t1[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1};
        t1[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b1};
        t1[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};

        t5[0]  = '{1'b1, 8'hB0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
        t5[1]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1};
        t5[2]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, 5'd2, 1'b1};
        t5[3]  = '{1'b1, 8'hB3, 1'b0, 1'b1, 8'hB0, 5'd3, 1'b1};
        t5[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 5'd4, 1'b1};
        t5[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB0, 5'd4, 1'b1};
        t5[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 5'd3, 1'b1};
        t5[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB1, 5'd3, 1'b1};
        t5[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 5'd2, 1'b1};
        t5[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 5'd2, 1'b1};
        t5[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 5'd1, 1'b1};
        t5[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};

        // Reset, with a write offered to prove it is gated off.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_ir", 32'(bus.in_ready), 32'd0);
        chk("rst_wren", 32'(bus.ram_wrEn), 32'd0);
        cyc();
        cyc();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_od", 32'(bus.out_data), 32'd0);
        chk("rst_lvl", 32'(bus.level), 32'd0);
        chk("rst_ir1", 32'(bus.in_ready), 32'd1);
        cyc();

        for (int i = 0; i < 5; i++)
            apply(t1[i], "t1");

        for (int i = 0; i < 12; i++)
            apply(t5[i], "t5");

        // Fill to capacity with the consumer stalled, then drain.
        bus.out_ready = 1'b0;
        nxt = 0;
        for (int c = 0; c < 25; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(nxt);
            @(negedge clk);
            f = bus.in_ready;
            cyc();
            if (f)
                nxt++;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_accepted", 32'(nxt), 32'd18);
        chk("t2_ir_full", 32'(bus.in_ready), 32'd0);
        chk("t2_lvl_full", 32'(bus.level), 32'd18);
        cyc();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("t2_ov", 32'(bus.out_valid), 32'd1);
            chk("t2_od", 32'(bus.out_data), 32'(i));
            cyc();
        end
        @(negedge clk);
        chk("t2_empty_ov", 32'(bus.out_valid), 32'd0);
        cyc();

        // Streaming: first output after 3 cycles, then one every cycle.
        p0 = npop;
        nxt = 8'h40;
        for (int c = 0; c < 50; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(nxt);
            @(negedge clk);
            f = bus.in_ready;
            cyc();
            if (f)
                nxt++;
        end
        chk("t3_pops", 32'(npop - p0), 32'd47);
        drain("t3_drain");

        // Random traffic across several pointer wraps.
        void'($urandom(32'd20240611));
        p0 = npop;
        q0 = npush;
        sent = 0;
        for (int c = 0; c < 3000 && (npush - q0) < 200; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = W'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        chk("t4_pushed", 32'(npush - q0), 32'd200);
        drain("t4_drain");
        chk("t4_popped", 32'(npop - p0), 32'd200);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with 10 entries queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(8'h50 + i);
            cyc();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_lvl10", 32'(bus.level), 32'd10);
        cyc();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        @(negedge clk);
        chk("t6_wren_rst", 32'(bus.ram_wrEn), 32'd0);
        cyc();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_ov", 32'(bus.out_valid), 32'd0);
        chk("t6_lvl", 32'(bus.level), 32'd0);
        chk("t6_ir", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        cyc();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                chk("t6_first", 32'(bus.out_data), 32'h3C);
            end
            cyc();
        end
        chk("t6_seen", 32'(seen), 32'd1);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller that wraps the team's dual-port synchronous RAM, which has 1-cycle registered read latency. Write side: accepts a valid/ready stream and drives the RAM write port. Read side: issues RAM reads and absorbs the read latency in a 2-entry output skid buffer, presenting a valid/ready stream downstream. The RAM is instantiated outside this block; this block connects only to its ports.

Parameters:
Width, 8, data width; must match the RAM Width.
Depth, 16, RAM entries; power of two, >= 2; must match the RAM Depth.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  producer has data.
in_ready  output  1  block can accept; in_fire = in_valid & in_ready.
in_data  input  Width  write data.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts; pop = out_valid & out_ready.
out_data  output  Width  head-of-queue data.
level  output  $clog2(Depth+4)  entries held: ram_count + pend + ob_count.
ram_wrEn  output  1  to RAM wrEn; equals in_fire.
ram_wrAddr  output  $clog2(Depth)  to RAM wrAddr; equals wr_ptr.
ram_wrData  output  Width  to RAM wrData; equals in_data.
ram_rdAddr  output  $clog2(Depth)  to RAM rdAddr; equals rd_ptr.
ram_rdData  input  Width  from RAM rdData; valid the cycle after a read is issued.

Behaviour:
- Reset is synchronous and active-low. rst_n sampled low at a posedge clears all of the following:
  - wr_ptr, rd_ptr, ram_count, pend, ob_count, level.
  - out_valid (driven 0).
  - out_data (cleared to 0).
- While rst_n = 0: in_ready = 0 and ram_wrEn = 0. RAM contents are not cleared.
- Reset mid-operation discards all queued data. No pre-reset entry may ever appear at out_data.
- Internal state:
  - wr_ptr, rd_ptr: RAM address pointers, wrap Depth-1 -> 0 naturally.
  - ram_count: 0..Depth, entries committed in RAM and not yet read.
  - pend: 1-bit flag, a RAM read was issued last cycle.
  - ob: 2-entry output buffer (ob0 = head, ob1); ob_count 0..2.
- Write side:
  - in_ready = (ram_count < Depth) when not in reset. Combinational from registered count; no same-cycle pass-through when full.
  - in_fire: RAM written at the edge; wr_ptr += 1; ram_count += 1.
- Read issue: rd_fire = (ram_count > 0) & (ob_count + pend - pop < 2).
  - On rd_fire: rd_ptr += 1; ram_count -= 1; pend <= 1. Otherwise pend <= 0.
  - ram_rdAddr = rd_ptr every cycle. The RAM's read is harmless when no read is issued.
- Simultaneous in_fire and rd_fire: ram_count unchanged.
- Read-during-write hazard cannot occur: reads target only entries whose write edge has already passed.
- Landing: when pend = 1, ram_rdData is written into ob at the edge.
  - Goes into slot ob0 if the buffer is empty after this cycle's pop, else into ob1.
- Pop: ob1 shifts to ob0. Pop and land in the same cycle keep FIFO order.
- out_valid = (ob_count > 0); out_data = ob0. Both are registered; out_data holds stable while out_valid & !out_ready.
- Latency: in_fire in cycle 0 on an empty FIFO -> RAM read issued cycle 1 -> rdData valid cycle 2 -> out_valid = 1 in cycle 3.
- Throughput: 1 transfer/cycle sustained in both directions with no bubbles.
- Capacity: Depth + 2 entries (RAM + ob). level max = Depth + 2.
- Simultaneous in_fire and pop: level unchanged.

Test Plan:
1. Reset, then in_data = 0xA5 pushed in cycle 0 with out_ready = 1 -> out_valid = 1 and out_data = 0xA5 in cycle 3; level 0 -> 1 -> 1 -> 1 -> 0.
2. out_ready = 0, in_valid = 1 pushing 0x00..0x13 -> exactly 18 accepted (0x00..0x11), in_ready = 0, level = 18. Then out_ready = 1 -> 0x00..0x11 emerge in order, one per cycle.
3. in_valid = out_ready = 1 continuously for 50 cycles with incrementing data -> after the 3-cycle fill, one output per cycle, no gaps, in order.
4. Random in_valid/out_ready (seeded) for 200 transfers, covering multiple pointer wraps -> output sequence equals input sequence; level always equals pushes - pops.
5. out_ready toggled 1,0,1,0 with 4 entries queued -> out_data unchanged in each stalled cycle; no duplicate or dropped values.
6. Fill to level = 10, drive rst_n = 0 for one cycle -> next cycle out_valid = 0, level = 0, in_ready = 1. Push 0x3C -> first output is 0x3C.
